// File: rtl/fir_wl_batch_ctrl.sv
// Batch sequencer for the word-length-configurable FIR: applies the tap word-length
// table, flushes the FIR, streams one batch from sample RAM and captures the results.
module fir_wl_batch_ctrl #(
   parameter int N_TAPS    = 30,
   parameter int DATA_WL   = 16,
   parameter int ADDR_WL   = 8,
   parameter int DRAIN_MAX = 64,
   parameter int WL_RST    = 24
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               cfg_we,
   input  logic [4:0]         cfg_addr,
   input  logic [7:0]         cfg_data,
   input  logic               start,
   input  logic [ADDR_WL:0]   batch_len,
   output logic               busy,
   output logic               done,
   output logic               err,
   output logic [7:0]         frac_wl [N_TAPS-1:0],
   output logic               src_rd,
   output logic [ADDR_WL-1:0] src_addr,
   input  logic [DATA_WL-1:0] src_data,
   output logic [DATA_WL-1:0] fir_data_in,
   output logic               fir_in_valid,
   input  logic [DATA_WL-1:0] fir_data_out,
   input  logic               fir_out_valid,
   output logic               res_we,
   output logic [ADDR_WL-1:0] res_addr,
   output logic [DATA_WL-1:0] res_data
);

   localparam int FW = $clog2(N_TAPS);
   localparam int DW = $clog2(DRAIN_MAX + 1);
   localparam int CW = ADDR_WL + 1;
   localparam logic [FW-1:0] FLUSH_LAST = FW'(N_TAPS - 1);
   localparam logic [DW-1:0] DRAIN_LAST = DW'(DRAIN_MAX - 1);
   localparam logic [7:0]    WL_INIT    = 8'(WL_RST);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_FLUSH  = 3'd1,
      S_STREAM = 3'd2,
      S_DRAIN  = 3'd3,
      S_DONE   = 3'd4
   } state_t;

   state_t             state_q, state_d;
   logic [CW-1:0]      len_q, len_d;
   logic [CW-1:0]      smp_cnt_q, smp_cnt_d;
   logic [CW-1:0]      res_cnt_q, res_cnt_d;
   logic [FW-1:0]      flush_cnt_q, flush_cnt_d;
   logic [DW-1:0]      drain_cnt_q, drain_cnt_d;
   logic [7:0]         shadow_q [N_TAPS-1:0];
   logic [7:0]         shadow_d [N_TAPS-1:0];
   logic [7:0]         active_q [N_TAPS-1:0];
   logic [7:0]         active_d [N_TAPS-1:0];
   logic               busy_q, busy_d;
   logic               done_q, done_d;
   logic               err_q, err_d;
   logic               src_rd_q, src_rd_d;
   logic [ADDR_WL-1:0] src_addr_q, src_addr_d;
   logic               fiv_q, fiv_d;
   logic               res_we_q, res_we_d;
   logic [ADDR_WL-1:0] res_addr_q, res_addr_d;
   logic [DATA_WL-1:0] res_data_q, res_data_d;

   always_comb begin
      state_d     = state_q;
      len_d       = len_q;
      smp_cnt_d   = smp_cnt_q;
      res_cnt_d   = res_cnt_q;
      flush_cnt_d = flush_cnt_q;
      drain_cnt_d = drain_cnt_q;
      shadow_d    = shadow_q;
      active_d    = active_q;
      err_d       = err_q;
      src_rd_d    = 1'b0;
      src_addr_d  = src_addr_q;
      res_we_d    = 1'b0;
      res_addr_d  = res_addr_q;
      res_data_d  = res_data_q;

      case (state_q)
         S_IDLE: begin
            if (start && (batch_len != {CW{1'b0}})) begin
               state_d     = S_FLUSH;
               len_d       = batch_len;
               active_d    = shadow_q;
               err_d       = 1'b0;
               smp_cnt_d   = {CW{1'b0}};
               res_cnt_d   = {CW{1'b0}};
               flush_cnt_d = {FW{1'b0}};
               drain_cnt_d = {DW{1'b0}};
            end else begin
               state_d = S_IDLE;
            end
         end
         // The first read is issued from the last flush cycle so src_rd is registered.
         S_FLUSH: begin
            if (flush_cnt_q == FLUSH_LAST) begin
               state_d     = S_STREAM;
               flush_cnt_d = {FW{1'b0}};
               src_rd_d    = 1'b1;
               src_addr_d  = {ADDR_WL{1'b0}};
               smp_cnt_d   = {{(CW-1){1'b0}}, 1'b1};
            end else begin
               flush_cnt_d = flush_cnt_q + {{(FW-1){1'b0}}, 1'b1};
            end
         end
         S_STREAM: begin
            if (smp_cnt_q == len_q) begin
               state_d = S_DRAIN;
            end else begin
               src_rd_d   = 1'b1;
               src_addr_d = smp_cnt_q[ADDR_WL-1:0];
               smp_cnt_d  = smp_cnt_q + {{(CW-1){1'b0}}, 1'b1};
            end
         end
         S_DRAIN: begin
            if (res_cnt_q == len_q) begin
               state_d = S_DONE;
            end else if (drain_cnt_q == DRAIN_LAST) begin
               state_d = S_DONE;
               err_d   = 1'b1;
            end else begin
               drain_cnt_d = drain_cnt_q + {{(DW-1){1'b0}}, 1'b1};
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      if (((state_q == S_STREAM) || (state_q == S_DRAIN)) && fir_out_valid && (res_cnt_q < len_q)) begin
         res_we_d   = 1'b1;
         res_addr_d = res_cnt_q[ADDR_WL-1:0];
         res_data_d = fir_data_out;
         res_cnt_d  = res_cnt_q + {{(CW-1){1'b0}}, 1'b1};
      end else begin
         res_we_d = 1'b0;
      end

      // Shadow write follows the copy above, so a same-cycle write misses this run.
      if (cfg_we && (int'(cfg_addr) < N_TAPS)) begin
         shadow_d[cfg_addr] = cfg_data;
      end else begin
         shadow_d = shadow_q;
      end

      busy_d = (state_d == S_FLUSH) || (state_d == S_STREAM) || (state_d == S_DRAIN);
      done_d = (state_d == S_DONE);
      fiv_d  = src_rd_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         len_q       <= {CW{1'b0}};
         smp_cnt_q   <= {CW{1'b0}};
         res_cnt_q   <= {CW{1'b0}};
         flush_cnt_q <= {FW{1'b0}};
         drain_cnt_q <= {DW{1'b0}};
         for (int i = 0; i < N_TAPS; i++) begin
            shadow_q[i] <= WL_INIT;
            active_q[i] <= WL_INIT;
         end
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         err_q       <= 1'b0;
         src_rd_q    <= 1'b0;
         src_addr_q  <= {ADDR_WL{1'b0}};
         fiv_q       <= 1'b0;
         res_we_q    <= 1'b0;
         res_addr_q  <= {ADDR_WL{1'b0}};
         res_data_q  <= {DATA_WL{1'b0}};
      end else begin
         state_q     <= state_d;
         len_q       <= len_d;
         smp_cnt_q   <= smp_cnt_d;
         res_cnt_q   <= res_cnt_d;
         flush_cnt_q <= flush_cnt_d;
         drain_cnt_q <= drain_cnt_d;
         for (int i = 0; i < N_TAPS; i++) begin
            shadow_q[i] <= shadow_d[i];
            active_q[i] <= active_d[i];
         end
         busy_q      <= busy_d;
         done_q      <= done_d;
         err_q       <= err_d;
         src_rd_q    <= src_rd_d;
         src_addr_q  <= src_addr_d;
         fiv_q       <= fiv_d;
         res_we_q    <= res_we_d;
         res_addr_q  <= res_addr_d;
         res_data_q  <= res_data_d;
      end
   end

   // RAM data arrives alongside fir_in_valid, so the input mux stays combinational.
   assign fir_data_in  = fiv_q ? src_data : {DATA_WL{1'b0}};
   assign fir_in_valid = fiv_q;
   assign frac_wl      = active_q;
   assign busy         = busy_q;
   assign done         = done_q;
   assign err          = err_q;
   assign src_rd       = src_rd_q;
   assign src_addr     = src_addr_q;
   assign res_we       = res_we_q;
   assign res_addr     = res_addr_q;
   assign res_data     = res_data_q;

endmodule

// File: tb/tb_fir_wl_batch_ctrl.sv
// Directed bench for fir_wl_batch_ctrl with a sample RAM, a behavioural 30-tap FIR
// and a result scoreboard checked on every res_we.
module tb_fir_wl_batch_ctrl;
   localparam int N = 30;

   logic        clk = 1'b0;
   logic        rst, cfg_we, start, busy, done, err;
   logic [4:0]  cfg_addr;
   logic [7:0]  cfg_data;
   logic [8:0]  batch_len;
   logic [7:0]  frac_wl [N-1:0];
   logic        src_rd, fir_in_valid, fir_out_valid, res_we;
   logic [7:0]  src_addr, res_addr;
   logic [15:0] src_data, fir_data_in, fir_data_out, res_data;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   fir_wl_batch_ctrl dut (
      .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
      .start(start), .batch_len(batch_len), .busy(busy), .done(done), .err(err),
      .frac_wl(frac_wl), .src_rd(src_rd), .src_addr(src_addr), .src_data(src_data),
      .fir_data_in(fir_data_in), .fir_in_valid(fir_in_valid),
      .fir_data_out(fir_data_out), .fir_out_valid(fir_out_valid),
      .res_we(res_we), .res_addr(res_addr), .res_data(res_data)
   );

   logic [15:0] mem [256];
   always @(posedge clk) if (src_rd) src_data <= mem[src_addr];

   // Behavioural FIR: products truncated to frac_wl fractional bits, latency N cycles.
   logic signed [15:0] cf [N];
   logic [15:0]        xh [N];
   logic               vp [N];
   logic [15:0]        yp [N];
   logic signed [39:0] acc;
   logic               fir_mute;
   logic [7:0]         exp_wl [N];
   logic [23:0]        sb [$];

   function automatic logic signed [31:0] mul(input logic [15:0] a, input logic [15:0] b);
      return 32'(signed'(a)) * 32'(signed'(b));
   endfunction

   function automatic logic signed [31:0] qnt(input logic signed [31:0] p, input logic [7:0] wl);
      int sh;
      sh = (wl >= 8'd24) ? 0 : 24 - int'(wl);
      return (p >>> sh) <<< sh;
   endfunction

   always_comb begin
      acc = 40'sd0;
      acc += 40'(qnt(mul(fir_data_in, cf[0]), frac_wl[0]));
      for (int k = 1; k < N; k++) acc += 40'(qnt(mul(xh[k-1], cf[k]), frac_wl[k]));
   end

   always @(posedge clk) begin
      xh[0] <= fir_data_in;
      vp[0] <= fir_in_valid;
      yp[0] <= acc[27:12];
      for (int k = 1; k < N; k++) begin
         xh[k] <= xh[k-1];
         vp[k] <= vp[k-1];
         yp[k] <= yp[k-1];
      end
   end

   assign fir_out_valid = vp[N-1] & ~fir_mute;
   assign fir_data_out  = yp[N-1];

   function automatic logic [15:0] ref_y(input int j);
      logic signed [39:0] s;
      s = 40'sd0;
      for (int k = 0; k < N && k <= j; k++) s += 40'(qnt(mul(mem[j-k], cf[k]), exp_wl[k]));
      return s[27:12];
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   always @(negedge clk) begin
      if (res_we) begin
         total++;
         assert (sb.size() != 0) else begin
            bad++;
            $error("FAIL res_unexpected observed=addr %0d expected=no write", res_addr);
         end
         if (sb.size() != 0) begin
            chk("res_addr", 32'(res_addr), 32'(sb[0][23:16]));
            chk("res_data", 32'(res_data), 32'(sb[0][15:0]));
            void'(sb.pop_front());
         end
      end
   end

   int w_busy, w_rd_first, w_rd_last, w_addr_first, w_addr_last, w_fiv_first, w_fiv_last;
   int w_we_first, w_we_last, w_we, w_done_first, w_done, w_err_first, w_err1;
   logic [7:0] wl_at1 [N];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic int wl_mis(input logic [7:0] v);
      int c = 0;
      for (int k = 0; k < N; k++) if (frac_wl[k] !== v) c++;
      return c;
   endfunction

   // Runs n cycles after the current one, recording cycle indices relative to it.
   task automatic watch(input int n, input int st_at, input logic [8:0] st_len,
                        input int cfg_at, input int rst_at);
      w_busy = 0; w_we = 0; w_done = 0; w_err1 = -1;
      w_rd_first = -1; w_rd_last = -1; w_addr_first = -1; w_addr_last = -1;
      w_fiv_first = -1; w_fiv_last = -1; w_we_first = -1; w_we_last = -1;
      w_done_first = -1; w_err_first = -1;
      for (int i = 1; i <= n; i++) begin
         tick();
         start = 1'b0; cfg_we = 1'b0; rst = 1'b0;
         if (busy) w_busy++;
         if (src_rd) begin
            if (w_rd_first < 0) begin w_rd_first = i; w_addr_first = int'(src_addr); end
            w_rd_last = i; w_addr_last = int'(src_addr);
         end
         if (fir_in_valid) begin
            if (w_fiv_first < 0) w_fiv_first = i;
            w_fiv_last = i;
         end
         if (res_we) begin
            if (w_we_first < 0) w_we_first = i;
            w_we_last = i; w_we++;
         end
         if (done) begin
            if (w_done_first < 0) w_done_first = i;
            w_done++;
         end
         if (err && w_err_first < 0) w_err_first = i;
         if (i == 1) begin
            w_err1 = int'(err);
            for (int k = 0; k < N; k++) wl_at1[k] = frac_wl[k];
         end
         if (i == st_at) begin start = 1'b1; batch_len = st_len; end
         if (i == cfg_at) begin cfg_we = 1'b1; cfg_addr = 5'd5; cfg_data = 8'd8; end
         if (i == rst_at) rst = 1'b1;
      end
   endtask

   initial begin
      int m;
      rst = 1'b1; start = 1'b0; batch_len = 9'd0; cfg_we = 1'b0; cfg_addr = 5'd0;
      cfg_data = 8'd0; fir_mute = 1'b0; src_data = 16'd0;
      for (int k = 0; k < N; k++) begin
         cf[k] = 16'(((k * 53 + 17) % 400 - 200) * 8);
         xh[k] = 16'd0; vp[k] = 1'b0; yp[k] = 16'd0;
         exp_wl[k] = 8'd24;
      end
      for (int i = 0; i < 256; i++) mem[i] = 16'd0;
      repeat (3) tick();
      rst = 1'b0;
      tick();

      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_err", 32'(err), 32'd0);
      chk("rst_src_rd", 32'(src_rd), 32'd0);
      chk("rst_fiv", 32'(fir_in_valid), 32'd0);
      chk("rst_res_we", 32'(res_we), 32'd0);
      chk("rst_wl", 32'(wl_mis(8'd24)), 32'd0);

      for (int t = 0; t < N; t++) begin
         cfg_we = 1'b1; cfg_addr = 5'(t); cfg_data = 8'd12;
         tick();
      end
      cfg_we = 1'b0;

      // Impulse batch, len 4; stray start in STREAM, shadow write in DRAIN.
      mem[0] = 16'h1000;
      for (int j = 0; j < 4; j++) sb.push_back({8'(j), 16'(cf[j])});
      chk("wl_pre_accept", 32'(wl_mis(8'd24)), 32'd0);
      start = 1'b1; batch_len = 9'd4;
      watch(75, 32, 9'd4, 40, -1);
      m = 0;
      for (int k = 0; k < N; k++) if (wl_at1[k] !== 8'd12) m++;
      chk("wl_applied", 32'(m), 32'd0);
      chk("b1_rd_first", 32'(w_rd_first), 32'd31);
      chk("b1_addr_first", 32'(w_addr_first), 32'd0);
      chk("b1_rd_last", 32'(w_rd_last), 32'd34);
      chk("b1_addr_last", 32'(w_addr_last), 32'd3);
      chk("b1_fiv_first", 32'(w_fiv_first), 32'd32);
      chk("b1_fiv_last", 32'(w_fiv_last), 32'd35);
      chk("b1_we_first", 32'(w_we_first), 32'd63);
      chk("b1_we_last", 32'(w_we_last), 32'd66);
      chk("b1_we_cnt", 32'(w_we), 32'd4);
      chk("b1_done_at", 32'(w_done_first), 32'd67);
      chk("b1_done_cnt", 32'(w_done), 32'd1);
      chk("b1_busy_cnt", 32'(w_busy), 32'd66);
      chk("b1_err", 32'(w_err_first), 32'hFFFF_FFFF);
      chk("b1_wl5_hold", 32'(frac_wl[5]), 32'd12);
      chk("b1_sb_empty", 32'(sb.size()), 32'd0);

      // Back-to-back start picks up the mid-run shadow write.
      mem[0] = 16'h0800; mem[1] = 16'h1234; mem[2] = 16'hF000; mem[3] = 16'h0ABC;
      mem[4] = 16'hFEDC; mem[5] = 16'h0777; mem[6] = 16'h1FFF; mem[7] = 16'hE001;
      for (int k = 0; k < N; k++) exp_wl[k] = 8'd12;
      exp_wl[5] = 8'd8;
      for (int j = 0; j < 8; j++) sb.push_back({8'(j), ref_y(j)});
      start = 1'b1; batch_len = 9'd8;
      watch(72, -1, 9'd0, -1, -1);
      chk("b2_wl5", 32'(wl_at1[5]), 32'd8);
      chk("b2_wl4", 32'(wl_at1[4]), 32'd12);
      chk("b2_done_at", 32'(w_done_first), 32'd71);
      chk("b2_we_cnt", 32'(w_we), 32'd8);
      chk("b2_sb_empty", 32'(sb.size()), 32'd0);

      // Drain timeout with a silent FIR.
      fir_mute = 1'b1;
      start = 1'b1; batch_len = 9'd4;
      watch(105, -1, 9'd0, -1, -1);
      chk("to_done_at", 32'(w_done_first), 32'd99);
      chk("to_err_at", 32'(w_err_first), 32'd99);
      chk("to_we_cnt", 32'(w_we), 32'd0);
      chk("to_done_cnt", 32'(w_done), 32'd1);
      chk("to_busy_cnt", 32'(w_busy), 32'd98);
      chk("to_err_sticky", 32'(err), 32'd1);

      // Minimum batch; accepted start clears err.
      fir_mute = 1'b0;
      mem[0] = 16'h0C35;
      sb.push_back({8'd0, ref_y(0)});
      start = 1'b1; batch_len = 9'd1;
      watch(66, -1, 9'd0, -1, -1);
      chk("l1_err_clr", 32'(w_err1), 32'd0);
      chk("l1_we_first", 32'(w_we_first), 32'd63);
      chk("l1_done_at", 32'(w_done_first), 32'd64);
      chk("l1_we_cnt", 32'(w_we), 32'd1);
      chk("l1_sb_empty", 32'(sb.size()), 32'd0);

      // Maximum batch: 256 samples, counters must not wrap.
      for (int i = 0; i < 256; i++) mem[i] = 16'($urandom_range(0, 16383)) - 16'h2000;
      for (int j = 0; j < 256; j++) sb.push_back({8'(j), ref_y(j)});
      start = 1'b1; batch_len = 9'd256;
      watch(322, -1, 9'd0, -1, -1);
      chk("l256_rd_first", 32'(w_rd_first), 32'd31);
      chk("l256_rd_last", 32'(w_rd_last), 32'd286);
      chk("l256_addr_last", 32'(w_addr_last), 32'd255);
      chk("l256_we_cnt", 32'(w_we), 32'd256);
      chk("l256_we_last", 32'(w_we_last), 32'd318);
      chk("l256_done_at", 32'(w_done_first), 32'd319);
      chk("l256_sb_empty", 32'(sb.size()), 32'd0);

      // Reset in the second STREAM cycle.
      start = 1'b1; batch_len = 9'd4;
      watch(33, -1, 9'd0, -1, 32);
      chk("mr_rd_first", 32'(w_rd_first), 32'd31);
      chk("mr_done_cnt", 32'(w_done), 32'd0);
      chk("mr_busy", 32'(busy), 32'd0);
      chk("mr_done", 32'(done), 32'd0);
      chk("mr_err", 32'(err), 32'd0);
      chk("mr_src_rd", 32'(src_rd), 32'd0);
      chk("mr_fiv", 32'(fir_in_valid), 32'd0);
      chk("mr_res_we", 32'(res_we), 32'd0);
      chk("mr_src_addr", 32'(src_addr), 32'd0);
      chk("mr_res_addr", 32'(res_addr), 32'd0);
      chk("mr_fir_din", 32'(fir_data_in), 32'd0);
      chk("mr_res_data", 32'(res_data), 32'd0);
      chk("mr_wl", 32'(wl_mis(8'd24)), 32'd0);
      watch(80, 2, 9'd0, -1, -1);
      chk("z_busy_cnt", 32'(w_busy), 32'd0);
      chk("z_done_cnt", 32'(w_done), 32'd0);
      chk("z_we_cnt", 32'(w_we), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
